vector_reg_file: RTL

VECTOR_REG_FILE -- requirements
Module: vector_reg_file

---
 rtl/vector_reg_file_pkg.sv | 19 +
 rtl/vector_reg_file_scoreboard.sv | 44 ++++
 rtl/vector_reg_file.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vector_reg_file_pkg.sv
// Shared definitions for the vector register file: special register indices and the data type.
// DATA_WIDTH defaults to 32 unless the build supplies its own `DATA_WIDTH.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vector_reg_file_pkg;

  localparam int ZERO_REG       = 0;
  localparam int THREAD_ID_REG  = 1;
  localparam int BLOCK_ID_REG   = 2;
  localparam int BLOCK_SIZE_REG = 3;

  // First index that is backed by real storage and tracked by the scoreboard.
  localparam int FIRST_GP_REG   = 4;

  typedef logic [`DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/vector_reg_file_scoreboard.sv
// reg_scoreboard: one busy bit per register, with a set port, a clear port and three query ports.
// A set and a clear to the same index in one cycle leaves the bit set.
module reg_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  input  logic [ADDR_WIDTH-1:0] i_query_a,
  input  logic [ADDR_WIDTH-1:0] i_query_b,
  input  logic [ADDR_WIDTH-1:0] i_query_c,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_busy_c,
  output logic [NUM_REGS-1:0]   o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (i_set_en) w_set_vec[i_set_addr] = 1'b1;
    if (i_clr_en) w_clr_vec[i_clr_addr] = 1'b1;
  end

  // Clear is applied first so a same-cycle reservation survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
  end

  assign o_busy   = r_busy;
  assign o_busy_a = r_busy[i_query_a];
  assign o_busy_b = r_busy[i_query_b];
  assign o_busy_c = r_busy[i_query_c];

endmodule

// File: rtl/vector_reg_file.sv
// vector_reg_file: per-lane register file with special read-only indices 0..3, a reservation scoreboard
// and a one-cycle operand read. Define REG_FILE_BYPASS_EN to forward same-cycle write-backs to reads.
module vector_reg_file
  import vector_reg_file_pkg::*;
#(
  parameter int THREADS_PER_WARP = 32,
  parameter int DATA_WIDTH       = `DATA_WIDTH,
  parameter int NUM_REGS         = 32,
  parameter int ADDR_WIDTH       = $clog2(NUM_REGS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DATA_WIDTH-1:0]                  warp_id,
  input  logic [DATA_WIDTH-1:0]                  block_id,
  input  logic [DATA_WIDTH-1:0]                  block_size,
  input  logic                                   rd_req_valid,
  output logic                                   rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]                  rs1_addr,
  input  logic [ADDR_WIDTH-1:0]                  rs2_addr,
  input  logic                                   rd_reserve,
  input  logic [ADDR_WIDTH-1:0]                  rd_reserve_addr,
  output logic                                   rd_resp_valid,
  output logic [THREADS_PER_WARP*DATA_WIDTH-1:0] rs1,
  output logic [THREADS_PER_WARP*DATA_WIDTH-1:0] rs2,
  input  logic                                   wb_valid,
  input  logic [ADDR_WIDTH-1:0]                  wb_addr,
  input  logic [THREADS_PER_WARP-1:0]            wb_mask,
  input  logic [THREADS_PER_WARP*DATA_WIDTH-1:0] wb_data,
  output logic [NUM_REGS-1:0]                    busy
);

  localparam int VEC_W = THREADS_PER_WARP * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_ZERO  = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] A_TID   = ADDR_WIDTH'(THREAD_ID_REG);
  localparam logic [ADDR_WIDTH-1:0] A_BID   = ADDR_WIDTH'(BLOCK_ID_REG);
  localparam logic [ADDR_WIDTH-1:0] A_BSZ   = ADDR_WIDTH'(BLOCK_SIZE_REG);
  localparam logic [ADDR_WIDTH-1:0] A_GP    = ADDR_WIDTH'(FIRST_GP_REG);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS][THREADS_PER_WARP];
  logic                  r_resp_valid;
  logic [VEC_W-1:0]      r_rs1;
  logic [VEC_W-1:0]      r_rs2;

  logic w_rs1_gp, w_rs2_gp, w_rd_gp, w_wb_gp;
  logic w_wb_hit1, w_wb_hit2;
  logic w_busy1, w_busy2, w_busy_rd;
  logic w_stall1, w_stall2, w_waw;
  logic w_accept, w_reserve;
  logic [VEC_W-1:0]      w_rs1_next, w_rs2_next;
  logic [DATA_WIDTH-1:0] w_tid, w_stored1, w_stored2;

  assign w_rs1_gp  = rs1_addr >= A_GP;
  assign w_rs2_gp  = rs2_addr >= A_GP;
  assign w_rd_gp   = rd_reserve_addr >= A_GP;
  assign w_wb_gp   = wb_valid && (wb_addr >= A_GP);
  assign w_wb_hit1 = w_wb_gp && w_rs1_gp && (wb_addr == rs1_addr);
  assign w_wb_hit2 = w_wb_gp && w_rs2_gp && (wb_addr == rs2_addr);

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_set_en  (w_reserve),
    .i_set_addr(rd_reserve_addr),
    .i_clr_en  (w_wb_gp),
    .i_clr_addr(wb_addr),
    .i_query_a (rs1_addr),
    .i_query_b (rs2_addr),
    .i_query_c (rd_reserve_addr),
    .o_busy_a  (w_busy1),
    .o_busy_b  (w_busy2),
    .o_busy_c  (w_busy_rd),
    .o_busy    (busy)
  );

`ifdef REG_FILE_BYPASS_EN
  assign w_stall1 = w_rs1_gp && w_busy1 && !w_wb_hit1;
  assign w_stall2 = w_rs2_gp && w_busy2 && !w_wb_hit2;
`else
  assign w_stall1 = w_rs1_gp && (w_busy1 || w_wb_hit1);
  assign w_stall2 = w_rs2_gp && (w_busy2 || w_wb_hit2);
`endif
  assign w_waw        = rd_reserve && w_rd_gp && w_busy_rd;
  assign rd_req_ready = !(w_stall1 || w_stall2 || w_waw);
  assign w_accept     = rd_req_valid && rd_req_ready;
  assign w_reserve    = w_accept && rd_reserve && w_rd_gp;

  function automatic logic [DATA_WIDTH-1:0] pickOperand(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] threadId,
    input logic [DATA_WIDTH-1:0] blockId,
    input logic [DATA_WIDTH-1:0] blockSize,
    input logic [DATA_WIDTH-1:0] stored
  );
    case (addr)
      A_ZERO:  return '0;
      A_TID:   return threadId;
      A_BID:   return blockId;
      A_BSZ:   return blockSize;
      default: return stored;
    endcase
  endfunction

  always_comb begin
    w_rs1_next = '0;
    w_rs2_next = '0;
    w_tid      = '0;
    w_stored1  = '0;
    w_stored2  = '0;
    for (int lane = 0; lane < THREADS_PER_WARP; lane++) begin
      w_tid     = warp_id * DATA_WIDTH'(THREADS_PER_WARP) + DATA_WIDTH'(lane);
      w_stored1 = r_regs[rs1_addr][lane];
      w_stored2 = r_regs[rs2_addr][lane];
`ifdef REG_FILE_BYPASS_EN
      if (w_wb_hit1 && wb_mask[lane]) w_stored1 = wb_data[lane*DATA_WIDTH +: DATA_WIDTH];
      if (w_wb_hit2 && wb_mask[lane]) w_stored2 = wb_data[lane*DATA_WIDTH +: DATA_WIDTH];
`endif
      w_rs1_next[lane*DATA_WIDTH +: DATA_WIDTH] =
        pickOperand(rs1_addr, w_tid, block_id, block_size, w_stored1);
      w_rs2_next[lane*DATA_WIDTH +: DATA_WIDTH] =
        pickOperand(rs2_addr, w_tid, block_id, block_size, w_stored2);
    end
  end

  // Operands are captured on accept and held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_rs1        <= '0;
      r_rs2        <= '0;
    end else begin
      r_resp_valid <= w_accept;
      if (w_accept) begin
        r_rs1 <= w_rs1_next;
        r_rs2 <= w_rs2_next;
      end
    end
  end

  // Write-backs to the special indices are dropped; only storage from index 4 upward is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        for (int l = 0; l < THREADS_PER_WARP; l++)
          r_regs[r][l] <= '0;
    end else if (w_wb_gp) begin
      for (int l = 0; l < THREADS_PER_WARP; l++)
        if (wb_mask[l]) r_regs[wb_addr][l] <= wb_data[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_resp_valid = r_resp_valid;
  assign rs1           = r_rs1;
  assign rs2           = r_rs2;

endmodule
